// File: rtl/ahb_timer_pkg.sv
// rtl/ahb_timer_pkg.sv - shared constants and types for the AHB timer slave
package ahb_timer_pkg;

    // Word offsets, i.e. haddr[4:2]
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_VALUE    = 3'd2;
    localparam logic [2:0] OFF_PRESCALE = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam logic [2:0] OFF_LIMIT    = 3'd5;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ONESHOT = 2;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } resp_state_e;

endpackage

// File: rtl/ahb_timer_s2_if.sv
// rtl/ahb_timer_s2_if.sv - AHB-Lite slave port 2 bundle
interface ahb_timer_s2_if;
    logic        hsel_s2;
    logic [31:0] haddr_s;
    logic [1:0]  htrans_s;
    logic        hwrite_s;
    logic [2:0]  hsize_s;
    logic [31:0] hwdata_s;
    logic        hready;
    logic        hready_resp_s2;
    logic [1:0]  hresp_s2;
    logic [31:0] hrdata_s2;

    modport slave (
        input  hsel_s2, haddr_s, htrans_s, hwrite_s, hsize_s, hwdata_s, hready,
        output hready_resp_s2, hresp_s2, hrdata_s2
    );

    modport master (
        output hsel_s2, haddr_s, htrans_s, hwrite_s, hsize_s, hwdata_s, hready,
        input  hready_resp_s2, hresp_s2, hrdata_s2
    );
endinterface

// File: rtl/ahb_timer_core.sv
// rtl/ahb_timer_core.sv - prescaler, down counter, pending flag and interrupt
module ahb_timer_core
    import ahb_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_we,
    input  logic             load_we,
    input  logic             pre_we,
    input  logic             status_we,
    input  logic [31:0]      wdata,
    output logic [2:0]       ctrl_q,
    output logic [CNT_W-1:0] load_q,
    output logic [CNT_W-1:0] value_q,
    output logic [PRE_W-1:0] prescale_q,
    output logic             pend_q,
    output logic             irq
);

    logic [PRE_W-1:0] pre_cnt;
    logic             en;
    logic             tick;
    logic             expire;

    assign en     = ctrl_q[CTRL_EN];
    assign tick   = en && (pre_cnt == prescale_q);
    // A LOAD write in the same cycle reloads the counter and suppresses expiry
    assign expire = tick && (value_q == '0) && !load_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= '0;
            ctrl_q     <= '0;
            load_q     <= '0;
            value_q    <= '0;
            prescale_q <= '0;
            pend_q     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (load_we || tick)
                pre_cnt <= '0;
            else if (en)
                pre_cnt <= pre_cnt + PRE_W'(1);

            if (ctrl_we)
                ctrl_q <= wdata[2:0];
            else if (expire && ctrl_q[CTRL_ONESHOT])
                ctrl_q[CTRL_EN] <= 1'b0;

            if (load_we)
                load_q <= wdata[CNT_W-1:0];

            if (pre_we)
                prescale_q <= wdata[PRE_W-1:0];

            if (load_we)
                value_q <= wdata[CNT_W-1:0];
            else if (tick) begin
                if (value_q != '0)
                    value_q <= value_q - CNT_W'(1);
                else if (!ctrl_q[CTRL_ONESHOT])
                    value_q <= load_q;
            end

            // Hardware set beats a simultaneous write-1-to-clear
            pend_q <= expire || (pend_q && !(status_we && wdata[0]));
            irq    <= pend_q && ctrl_q[CTRL_IE];
        end
    end

endmodule

// File: rtl/ahb_timer_s2.sv
// rtl/ahb_timer_s2.sv - AHB-Lite timer slave: decode, response FSM, read mux
module ahb_timer_s2
    import ahb_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic         HCLK,
    input  logic         HRESET,
    ahb_timer_s2_if.slave bus,
    output logic         timer_irq
);

    resp_state_e state, state_nxt;

    logic             accept;
    logic             illegal;
    logic             dp_ok;
    logic             dp_write;
    logic [2:0]       dp_off;
    logic             wr_commit;
    logic [2:0]       ctrl_q;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] value_q;
    logic [PRE_W-1:0] prescale_q;
    logic             pend_q;
    logic             unused_bits;

    assign accept  = bus.hsel_s2 && bus.htrans_s[1] && bus.hready;
    assign illegal = (bus.hsize_s != HSIZE_WORD)
                  || (bus.haddr_s[1:0] != 2'b00)
                  || (bus.haddr_s[4:2] >= OFF_LIMIT)
                  || (bus.hwrite_s && bus.haddr_s[4:2] == OFF_VALUE);
    assign unused_bits = ^{bus.htrans_s[0], bus.haddr_s[31:5]};

    // Address phase capture; only legal transfers open an OKAY data phase
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_ok    <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= '0;
        end else if (bus.hready) begin
            dp_ok    <= accept && !illegal;
            dp_write <= bus.hwrite_s;
            dp_off   <= bus.haddr_s[4:2];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            state <= ST_OK;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OK:   if (accept && illegal) state_nxt = ST_ERR1;
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = (accept && illegal) ? ST_ERR1 : ST_OK;
            default: state_nxt = ST_OK;
        endcase
    end

    always_comb begin
        bus.hready_resp_s2 = 1'b1;
        bus.hresp_s2       = HRESP_OKAY;
        case (state)
            ST_ERR1: begin
                bus.hready_resp_s2 = 1'b0;
                bus.hresp_s2       = HRESP_ERROR;
            end
            ST_ERR2: bus.hresp_s2 = HRESP_ERROR;
            default: ;
        endcase
    end

    assign wr_commit = dp_ok && dp_write && bus.hready;

    ahb_timer_core #(
        .CNT_W(CNT_W),
        .PRE_W(PRE_W)
    ) u_core (
        .clk        (HCLK),
        .rst        (HRESET),
        .ctrl_we    (wr_commit && dp_off == OFF_CTRL),
        .load_we    (wr_commit && dp_off == OFF_LOAD),
        .pre_we     (wr_commit && dp_off == OFF_PRESCALE),
        .status_we  (wr_commit && dp_off == OFF_STATUS),
        .wdata      (bus.hwdata_s),
        .ctrl_q     (ctrl_q),
        .load_q     (load_q),
        .value_q    (value_q),
        .prescale_q (prescale_q),
        .pend_q     (pend_q),
        .irq        (timer_irq)
    );

    always_comb begin
        bus.hrdata_s2 = '0;
        if (dp_ok && !dp_write) begin
            case (dp_off)
                OFF_CTRL:     bus.hrdata_s2 = {29'd0, ctrl_q};
                OFF_LOAD:     bus.hrdata_s2 = 32'(load_q);
                OFF_VALUE:    bus.hrdata_s2 = 32'(value_q);
                OFF_PRESCALE: bus.hrdata_s2 = 32'(prescale_q);
                OFF_STATUS:   bus.hrdata_s2 = {31'd0, pend_q};
                default:      bus.hrdata_s2 = '0;
            endcase
        end
    end

endmodule
